// File: rtl/gaussian_stream_mac.sv
// gaussian_stream_mac
//   Streaming Gaussian multiply-accumulate. Each accepted pixel is multiplied
//   by the coefficient of its tap position. TAPS products are summed per
//   window. The window sum is rounded half-up, saturated to DATA_W bits and
//   held in an output register with valid/ready backpressure.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   coef_we/coef_addr/coef_data  coefficient bank write (addr >= TAPS ignored)
//   clear                        drop the partial window (k, stage 1, acc)
//   in_valid/in_ready/pixel_in   pixel stream input
//   out_valid/out_ready/pixel_out window result output
module gaussian_stream_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 25,
    parameter int ID_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_we,
    input  logic [ID_W-1:0]   coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pixel_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] pixel_out
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + ID_W;
    localparam logic [ACC_W:0]   HALF   = (ACC_W+1)'(1) << (COEF_W - 1);
    localparam logic [ID_W-1:0]  LAST_K = ID_W'(TAPS - 1);

    logic [TAPS-1:0][COEF_W-1:0] coef;
    logic [COEF_W-1:0]           cur_coef;
    logic [ID_W-1:0]             k;

    logic                        s1_valid;
    logic                        s1_first;
    logic                        s1_last;
    logic [PROD_W-1:0]           s1_p;

    logic [ACC_W-1:0]            acc;
    logic [ACC_W-1:0]            sum;
    logic [ACC_W:0]              rnd;
    logic [DATA_W-1:0]           sat;

    logic                        stall;
    logic                        accept;
    logic                        load;

    // A full output register that is not being taken freezes the whole pipe.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall && !rst && !clear;
    assign accept   = in_valid && in_ready;
    // clear also blocks a completing window from reaching the output.
    assign load     = s1_valid && s1_last && !stall && !clear;

    // Coefficient read mux; the registered bank gives old-value-on-same-cycle
    // semantics for a write coinciding with an accept.
    always_comb begin
        cur_coef = '0;
        for (int i = 0; i < TAPS; i++)
            if (k == ID_W'(i)) cur_coef = coef[i];
    end

    // First tap restarts the sum, so windows run back to back without a bubble.
    // The extra top bit of rnd absorbs the rounding carry before saturation.
    always_comb begin
        sum = (s1_first ? '0 : acc) + ACC_W'(s1_p);
        rnd = ({1'b0, sum} + HALF) >> COEF_W;
        sat = (|rnd[ACC_W:DATA_W]) ? '1 : rnd[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coef <= '0;
        end else if (coef_we) begin
            for (int i = 0; i < TAPS; i++)
                if (coef_addr == ID_W'(i)) coef[i] <= coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= '0;
            s1_valid  <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            pixel_out <= '0;
        end else begin
            if (clear) begin
                k        <= '0;
                s1_valid <= 1'b0;
                acc      <= '0;
            end else if (!stall) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_p     <= PROD_W'(pixel_in) * PROD_W'(cur_coef);
                    s1_first <= (k == '0);
                    s1_last  <= (k == LAST_K);
                    k        <= (k == LAST_K) ? '0 : k + 1'b1;
                end
                if (s1_valid) acc <= sum;
            end

            if (load) begin
                pixel_out <= sat;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
